// File: rtl/hpm_counter_bank.sv
// Bank of machine-mode performance counters (mhpmcounter3+) with inhibit, overflow flags and registered CSR reads.
// Define HPM_SHADOW_EN to make the read-only user shadows at 0xC03+i readable.
module hpm_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 14,
  parameter int unsigned CNT_WIDTH    = 64,
  parameter int unsigned NUM_LANES    = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_COUNTERS*NUM_LANES-1:0] event_i,
  input  logic                              csr_re_i,
  input  logic                              csr_we_i,
  input  logic [11:0]                       csr_addr_i,
  input  logic [63:0]                       csr_wdata_i,
  output logic                              csr_rvalid_o,
  output logic [63:0]                       csr_rdata_o,
  output logic                              csr_illegal_o,
  output logic [NUM_COUNTERS-1:0]           overflow_o
);

  localparam int unsigned LW = $clog2(NUM_LANES + 1);
  localparam int unsigned SW = CNT_WIDTH + LW;
  localparam logic [11:0] INH_ADDR  = 12'h320;
  localparam logic [11:0] MCNT_BASE = 12'hB03;
`ifdef HPM_SHADOW_EN
  localparam logic [11:0] UCNT_BASE = 12'hC03;
`endif

  logic [CNT_WIDTH-1:0]    r_cnt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] r_inh;
  logic [NUM_COUNTERS-1:0] r_ovf;
  logic                    r_rvalid;
  logic                    r_illegal;
  logic [63:0]             r_rdata;

  logic [LW-1:0]           w_pop [NUM_COUNTERS];
  logic [SW-1:0]           w_sum [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] w_cnt_we;
  logic                    w_rd_ok;
  logic                    w_wr_ok;
  logic                    w_illegal;
  logic                    w_inh_we;
  logic [63:0]             w_rdata;

  always_comb begin
    w_rd_ok  = 1'b0;
    w_wr_ok  = 1'b0;
    w_rdata  = '0;
    w_cnt_we = '0;
    if (csr_addr_i == INH_ADDR) begin
      w_rd_ok = 1'b1;
      w_wr_ok = 1'b1;
      w_rdata[3 +: NUM_COUNTERS] = r_inh;
    end
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_addr_i == MCNT_BASE + 12'(i)) begin
        w_rd_ok = 1'b1;
        w_wr_ok = 1'b1;
        w_rdata = 64'(r_cnt[i]);
      end
`ifdef HPM_SHADOW_EN
      if (csr_addr_i == UCNT_BASE + 12'(i)) begin
        w_rd_ok = 1'b1;
        w_rdata = 64'(r_cnt[i]);
      end
`endif
    end
    // Any illegal half of a combined access suppresses both halves.
    w_illegal = (csr_re_i & ~w_rd_ok) | (csr_we_i & ~w_wr_ok);
    w_inh_we  = csr_we_i & ~w_illegal & (csr_addr_i == INH_ADDR);
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      w_cnt_we[i] = csr_we_i & ~w_illegal & (csr_addr_i == MCNT_BASE + 12'(i));
    end
  end

  // Extra LW high bits of the sum capture the carry out of the counter.
  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      w_pop[i] = '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        w_pop[i] = w_pop[i] + LW'(event_i[i*NUM_LANES + l]);
      end
      w_sum[i] = SW'(r_cnt[i]) + SW'(w_pop[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        if (w_cnt_we[i]) begin
          r_cnt[i] <= csr_wdata_i[CNT_WIDTH-1:0];
          r_ovf[i] <= 1'b0;
        end else if (!r_inh[i]) begin
          r_cnt[i] <= w_sum[i][CNT_WIDTH-1:0];
          if (|w_sum[i][CNT_WIDTH +: LW]) begin
            r_ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inh     <= '0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_inh_we) begin
        r_inh <= csr_wdata_i[3 +: NUM_COUNTERS];
      end
      r_rvalid  <= csr_re_i;
      r_illegal <= w_illegal;
      if (csr_re_i) begin
        r_rdata <= w_illegal ? '0 : w_rdata;
      end
    end
  end

  assign csr_rvalid_o  = r_rvalid;
  assign csr_rdata_o   = r_rdata;
  assign csr_illegal_o = r_illegal;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised and directed checks of hpm_counter_bank against a per-counter arithmetic model (4 counters, 8 bits, 2 lanes).
module tb_hpm_counter_bank;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int NL = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC*NL-1:0]  event_i = '0;
  logic              csr_re_i = 1'b0;
  logic              csr_we_i = 1'b0;
  logic [11:0]       csr_addr_i = '0;
  logic [63:0]       csr_wdata_i = '0;
  logic              csr_rvalid_o;
  logic [63:0]       csr_rdata_o;
  logic              csr_illegal_o;
  logic [NC-1:0]     overflow_o;

  int unsigned total = 0;
  int unsigned bad = 0;

  int unsigned   m_cnt [NC];
  logic [NC-1:0] m_ovf;
  logic [NC-1:0] m_inh;
  logic          e_rv;
  logic          e_il;
  logic [63:0]   e_rd;

  hpm_counter_bank #(
    .NUM_COUNTERS(NC),
    .CNT_WIDTH   (CW),
    .NUM_LANES   (NL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .event_i      (event_i),
    .csr_re_i     (csr_re_i),
    .csr_we_i     (csr_we_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_rvalid_o (csr_rvalid_o),
    .csr_rdata_o  (csr_rdata_o),
    .csr_illegal_o(csr_illegal_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_ovf = '0;
    m_inh = '0;
  endtask

  // One clock of stimulus; leaves the model's predictions in e_rv/e_rd/e_il.
  task automatic drive(input logic re, input logic we, input logic [11:0] addr,
                       input logic [63:0] wd, input logic [NC*NL-1:0] ev);
    int  boff;
    int  uoff;
    bit  bok;
    bit  uok;
    bit  rd_ok;
    bit  wr_ok;
    int unsigned s;
    @(negedge clk);
    csr_re_i = re; csr_we_i = we; csr_addr_i = addr; csr_wdata_i = wd; event_i = ev;
    boff = int'(addr) - 'hB03;
    uoff = int'(addr) - 'hC03;
    bok  = (boff >= 0) && (boff < NC);
    uok  = (uoff >= 0) && (uoff < NC);
    rd_ok = (addr == 12'h320) || bok;
`ifdef HPM_SHADOW_EN
    rd_ok = rd_ok || uok;
`endif
    wr_ok = (addr == 12'h320) || bok;
    e_il = (re && !rd_ok) || (we && !wr_ok);
    e_rv = re;
    e_rd = '0;
    if (re && !e_il) begin
      if (addr == 12'h320) e_rd = 64'(m_inh) << 3;
      else if (bok)        e_rd = 64'(m_cnt[boff]);
      else                 e_rd = 64'(m_cnt[uoff]);
    end
    @(posedge clk);
    for (int i = 0; i < NC; i++) begin
      if (we && !e_il && bok && boff == i) begin
        m_cnt[i] = int'(wd % (64'd1 << CW));
        m_ovf[i] = 1'b0;
      end else if (!m_inh[i]) begin
        s = m_cnt[i] + int'(ev[NL*i]) + int'(ev[NL*i+1]);
        if (s >= (1 << CW)) m_ovf[i] = 1'b1;
        m_cnt[i] = s % (1 << CW);
      end
    end
    if (we && !e_il && addr == 12'h320) m_inh = wd[3 +: NC];
    #1;
    csr_re_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; event_i = '0;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (csr_rvalid_o !== 1'b0 || csr_rdata_o !== 64'd0 || csr_illegal_o !== 1'b0 || overflow_o !== '0) begin
      bad++;
      $display("FAIL reset_state: rvalid=%b rdata=%0h ill=%b ovf=%b required 0/0/0/0",
               csr_rvalid_o, csr_rdata_o, csr_illegal_o, overflow_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== 64'd0 || overflow_o !== '0) begin
      bad++;
      $display("FAIL reset_read: rvalid=%b rdata=%0h ovf=%b required 1/0/0", csr_rvalid_o, csr_rdata_o, overflow_o);
    end
  endtask

  task automatic test_lanes();
    for (int c = 0; c < 5; c++) drive(0, 0, 0, 0, 8'b0000_0011);
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== 64'd10) begin
      bad++;
      $display("FAIL lanes_sum: rvalid=%b rdata=%0d required 1/10", csr_rvalid_o, csr_rdata_o);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 12'hB04, 64'hFE, 0);
    drive(0, 0, 0, 0, 8'b0000_1100);
    drive(0, 0, 0, 0, 8'b0000_0100);
    drive(1, 0, 12'hB04, 0, 0);
    total++;
    if (csr_rdata_o !== 64'h01 || overflow_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_value: rdata=%0h ovf1=%b required 01/1", csr_rdata_o, overflow_o[1]);
    end
    drive(0, 1, 12'hB04, 0, 0);
    total++;
    if (overflow_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear: ovf1=%b required 0", overflow_o[1]);
    end
    drive(0, 1, 12'hB04, 64'hFF, 0);
    drive(0, 1, 12'hB04, 64'h33, 8'b0000_1100);
    drive(1, 0, 12'hB04, 0, 0);
    total++;
    if (csr_rdata_o !== 64'h33 || overflow_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL write_beats_wrap: rdata=%0h ovf1=%b required 33/0", csr_rdata_o, overflow_o[1]);
    end
  endtask

  task automatic test_inhibit();
    logic [63:0] v;
    drive(1, 0, 12'hB03, 0, 0);
    v = e_rd;
    drive(0, 1, 12'h320, 64'h8, 0);
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 8'b0000_0011);
    drive(1, 0, 12'h320, 0, 0);
    total++;
    if (csr_rdata_o !== 64'h8) begin
      bad++;
      $display("FAIL inhibit_readback: rdata=%0h required 8", csr_rdata_o);
    end
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rdata_o !== v) begin
      bad++;
      $display("FAIL inhibit_hold: rdata=%0h required %0h", csr_rdata_o, v);
    end
    drive(0, 1, 12'h320, 64'hFFFF_FFFF_FFFF_FF80, 8'b0000_0001);
    drive(0, 0, 0, 0, 8'b0000_0001);
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rdata_o !== ((v + 64'd1) & 64'hFF)) begin
      bad++;
      $display("FAIL inhibit_resume: rdata=%0h required %0h", csr_rdata_o, (v + 64'd1) & 64'hFF);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] v;
    drive(1, 0, 12'hB03, 0, 0);
    v = e_rd;
    drive(1, 1, 12'hB03, 64'd100, 8'b0000_0011);
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== v || csr_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL rw_old_value: rvalid=%b rdata=%0d ill=%b required 1/%0d/0", csr_rvalid_o, csr_rdata_o, csr_illegal_o, v);
    end
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rdata_o !== 64'd100) begin
      bad++;
      $display("FAIL rw_new_value: rdata=%0d required 100", csr_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NC; k++) begin
      drive(1, 0, 12'hB03 + 12'(k), 0, 8'(($urandom % 256)));
      total++;
      if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== e_rd) begin
        bad++;
        $display("FAIL b2b_read%0d: rvalid=%b rdata=%0h required 1/%0h", k, csr_rvalid_o, csr_rdata_o, e_rd);
      end
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (csr_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL rvalid_pulse: rvalid=%b required 0", csr_rvalid_o);
    end
  endtask

  task automatic test_shadow_illegal();
    logic [63:0] v;
    drive(1, 0, 12'hB03, 0, 0);
    v = e_rd;
    drive(1, 0, 12'hC03, 0, 0);
`ifdef HPM_SHADOW_EN
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== v || csr_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL shadow_read: rvalid=%b rdata=%0h ill=%b required 1/%0h/0", csr_rvalid_o, csr_rdata_o, csr_illegal_o, v);
    end
`else
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== 64'd0 || csr_illegal_o !== 1'b1) begin
      bad++;
      $display("FAIL shadow_unmapped: rvalid=%b rdata=%0h ill=%b required 1/0/1", csr_rvalid_o, csr_rdata_o, csr_illegal_o);
    end
`endif
    drive(0, 1, 12'hC03, 64'h5A, 0);
    total++;
    if (csr_illegal_o !== 1'b1 || csr_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL shadow_write: ill=%b rvalid=%b required 1/0", csr_illegal_o, csr_rvalid_o);
    end
    drive(1, 0, 12'hB03, 0, 0);
    total++;
    if (csr_rdata_o !== v || csr_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL shadow_write_ignored: rdata=%0h ill=%b required %0h/0", csr_rdata_o, csr_illegal_o, v);
    end
    drive(1, 0, 12'hB03 + 12'(NC), 0, 0);
    total++;
    if (csr_illegal_o !== 1'b1 || csr_rvalid_o !== 1'b1 || csr_rdata_o !== 64'd0) begin
      bad++;
      $display("FAIL unmapped_read: ill=%b rvalid=%b rdata=%0h required 1/1/0", csr_illegal_o, csr_rvalid_o, csr_rdata_o);
    end
    drive(0, 1, 12'hB02, 64'h1, 0);
    total++;
    if (csr_illegal_o !== 1'b1) begin
      bad++;
      $display("FAIL unmapped_write: ill=%b required 1", csr_illegal_o);
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (csr_illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: ill=%b required 0", csr_illegal_o);
    end
  endtask

  task automatic test_random();
    int unsigned sel;
    logic re;
    logic we;
    logic [11:0] addr;
    logic [63:0] wd;
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 14);
      re  = 1'($urandom);
      we  = ($urandom % 4) == 0;
      wd  = {$urandom, $urandom};
      if (sel < 8)       addr = 12'hB03 + 12'(sel % NC);
      else if (sel < 10) begin
        addr = 12'h320;
        wd   = ($urandom % 2) ? 64'd0 : wd;
      end
      else if (sel < 14) addr = 12'hC03 + 12'(sel - 10);
      else               addr = 12'hB03 + 12'(NC);
      if (sel >= 10 && re && we) we = 1'b0;
      drive(re, we, addr, wd, 8'($urandom % 256));
      total++;
      if (csr_rvalid_o !== e_rv || (e_rv && csr_rdata_o !== e_rd) || csr_illegal_o !== e_il || overflow_o !== m_ovf) begin
        bad++;
        $display("FAIL random_c%0d addr=%0h: rv=%b rd=%0h ill=%b ovf=%b required %b/%0h/%b/%b",
                 c, addr, csr_rvalid_o, csr_rdata_o, csr_illegal_o, overflow_o, e_rv, e_rd, e_il, m_ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 12'hB05, 64'h77, 0);
    @(negedge clk);
    csr_re_i = 1'b1; csr_addr_i = 12'hB05; event_i = '1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    csr_re_i = 1'b0; csr_addr_i = '0; event_i = '0;
    total++;
    if (csr_rvalid_o !== 1'b0 || overflow_o !== '0 || csr_rdata_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid: rvalid=%b ovf=%b rdata=%0h required 0/0/0", csr_rvalid_o, overflow_o, csr_rdata_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 12'hB05, 0, 0);
    total++;
    if (csr_rdata_o !== 64'd0 || csr_rvalid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_read: rdata=%0h rvalid=%b required 0/1", csr_rdata_o, csr_rvalid_o);
    end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_wrap();
    test_inhibit();
    test_same_cycle();
    test_back_to_back();
    test_shadow_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
